evict_writeback: RTL and testbench

EVICT_WRITEBACK -- requirements
Module: evict_writeback

---
 rtl/evict_writeback.sv | 109 ++++++++++
 tb/tb_evict_writeback.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/evict_writeback.sv
// Eviction intake and dirty-line writeback queue.
// A victim index is read from the tag/data arrays; dirty lines are queued
// as {tag, idx, data} in a small FIFO that drains to memory over a
// valid/ready request channel.
module evict_writeback #(
    parameter int word_wid = 64,
    parameter int idx_wid  = 10,
    parameter int tag_wid  = 20,
    parameter int depth    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       evict_valid_i,
    input  logic [idx_wid-1:0]         evict_idx_i,
    output logic                       evict_ready_o,
    output logic                       arr_rd_en_o,
    output logic [idx_wid-1:0]         arr_rd_idx_o,
    input  logic [word_wid-1:0]        arr_data_i,
    input  logic [tag_wid-1:0]         arr_tag_i,
    input  logic                       arr_dirty_i,
    output logic                       arr_clr_dirty_o,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [tag_wid+idx_wid-1:0] mem_addr_o,
    output logic [word_wid-1:0]        mem_data_o,
    output logic                       overflow_o,
    output logic [15:0]                wb_count_o
);

    localparam int ptr_wid = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_wid = $clog2(depth) + 1;
    localparam int ent_wid = tag_wid + idx_wid + word_wid;

    typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;

    state_t               state;
    logic [idx_wid-1:0]   idx_q;
    logic [ent_wid-1:0]   fifo_mem [depth];
    logic [ptr_wid-1:0]   wr_ptr;
    logic [ptr_wid-1:0]   rd_ptr;
    logic [cnt_wid-1:0]   count;
    logic                 push;
    logic                 pop;

    // Accepting only with a free slot reserves room for the eventual push,
    // so the FIFO can never be written while full.
    assign evict_ready_o   = (state == IDLE) && (count < cnt_wid'(depth));
    assign arr_rd_en_o     = (state == READ);
    assign arr_rd_idx_o    = idx_q;
    assign push            = (state == CAPTURE) && arr_dirty_i;
    assign arr_clr_dirty_o = push;
    assign mem_valid_o     = (count != '0);
    assign pop             = mem_valid_o && mem_ready_i;
    assign {mem_addr_o, mem_data_o} = fifo_mem[rd_ptr];

    // Intake FSM: IDLE -> READ (array strobe) -> CAPTURE (sample line) -> IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (evict_valid_i && evict_ready_o) state <= READ;
                READ:    state <= CAPTURE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Victim index latch; held from READ through CAPTURE for the array.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && evict_valid_i && evict_ready_o) idx_q <= evict_idx_i;
    end

    // Sticky flag for offers dropped because upstream does not hold them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                               overflow_o <= 1'b0;
        else if (evict_valid_i && !evict_ready_o) overflow_o <= 1'b1;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_wid'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_wid'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_wid'(1);
                2'b01:   count <= count - cnt_wid'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: dirty line entry written as {tag, idx, data}.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= {arr_tag_i, idx_q, arr_data_i};
    end

    // Saturating count of writebacks handed to memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              wb_count_o <= 16'd0;
        else if (pop && wb_count_o != 16'hFFFF) wb_count_o <= wb_count_o + 16'd1;
    end

endmodule

// File: tb/tb_evict_writeback.sv
// Directed bench for evict_writeback: inputs driven and outputs sampled on
// the falling clock edge.
module tb_evict_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        evict_valid_i = 1'b0;
    logic [9:0]  evict_idx_i = '0;
    logic        evict_ready_o;
    logic        arr_rd_en_o;
    logic [9:0]  arr_rd_idx_o;
    logic [63:0] arr_data_i = '0;
    logic [19:0] arr_tag_i = '0;
    logic        arr_dirty_i = 1'b0;
    logic        arr_clr_dirty_o;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [29:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic        overflow_o;
    logic [15:0] wb_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    evict_writeback #(.word_wid(64), .idx_wid(10), .tag_wid(20), .depth(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .evict_valid_i(evict_valid_i), .evict_idx_i(evict_idx_i), .evict_ready_o(evict_ready_o),
        .arr_rd_en_o(arr_rd_en_o), .arr_rd_idx_o(arr_rd_idx_o),
        .arr_data_i(arr_data_i), .arr_tag_i(arr_tag_i), .arr_dirty_i(arr_dirty_i),
        .arr_clr_dirty_o(arr_clr_dirty_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .overflow_o(overflow_o), .wb_count_o(wb_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus-only helpers.
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        evict_valid_i = 1'b0;
        mem_ready_i = 1'b0;
        arr_dirty_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Pulse evict_valid_i for one cycle from a falling edge; returns at the next falling edge.
    task automatic offer(input logic [9:0] idx);
        evict_valid_i = 1'b1;
        evict_idx_i = idx;
        @(posedge clk_i);
        @(negedge clk_i);
        evict_valid_i = 1'b0;
    endtask

    task automatic set_line(input logic [19:0] tag, input logic [63:0] data, input logic dirty);
        arr_tag_i = tag;
        arr_data_i = data;
        arr_dirty_i = dirty;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid_o); end
        n_checks++; if (arr_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", arr_rd_en_o); end
        n_checks++; if (arr_clr_dirty_o !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b want 0", arr_clr_dirty_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        n_checks++; if (wb_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_wb_count: got %0d want 0", wb_count_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_checks++; if (evict_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", evict_ready_o); end
    endtask

    task automatic test_dirty();
        do_reset();
        mem_ready_i = 1'b1;
        set_line(20'hABCDE, 64'h1122334455667788, 1'b1);
        offer(10'h05A);
        n_checks++; if (arr_rd_en_o !== 1'b1) begin n_fail++; $display("FAIL dirty_rd_en: got %b want 1", arr_rd_en_o); end
        n_checks++; if (arr_rd_idx_o !== 10'h05A) begin n_fail++; $display("FAIL dirty_rd_idx: got %h want 05a", arr_rd_idx_o); end
        n_checks++; if (evict_ready_o !== 1'b0) begin n_fail++; $display("FAIL dirty_ready_read: got %b want 0", evict_ready_o); end
        @(negedge clk_i);
        n_checks++; if (arr_clr_dirty_o !== 1'b1) begin n_fail++; $display("FAIL dirty_clr: got %b want 1", arr_clr_dirty_o); end
        n_checks++; if (arr_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL dirty_rd_en_capture: got %b want 0", arr_rd_en_o); end
        n_checks++; if (arr_rd_idx_o !== 10'h05A) begin n_fail++; $display("FAIL dirty_rd_idx_capture: got %h want 05a", arr_rd_idx_o); end
        @(negedge clk_i);
        arr_dirty_i = 1'b0;
        n_checks++; if (mem_valid_o !== 1'b1) begin n_fail++; $display("FAIL dirty_mem_valid: got %b want 1", mem_valid_o); end
        n_checks++; if (mem_addr_o !== {20'hABCDE, 10'h05A}) begin n_fail++; $display("FAIL dirty_addr: got %h want %h", mem_addr_o, {20'hABCDE, 10'h05A}); end
        n_checks++; if (mem_data_o !== 64'h1122334455667788) begin n_fail++; $display("FAIL dirty_data: got %h want 1122334455667788", mem_data_o); end
        n_checks++; if (arr_clr_dirty_o !== 1'b0) begin n_fail++; $display("FAIL dirty_clr_idle: got %b want 0", arr_clr_dirty_o); end
        @(negedge clk_i);
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL dirty_drained: got %b want 0", mem_valid_o); end
        n_checks++; if (wb_count_o !== 16'd1) begin n_fail++; $display("FAIL dirty_wb_count: got %0d want 1", wb_count_o); end
    endtask

    task automatic test_clean();
        do_reset();
        mem_ready_i = 1'b1;
        set_line(20'h12345, 64'hDEADBEEFCAFEF00D, 1'b0);
        offer(10'h1C3);
        n_checks++; if (arr_rd_en_o !== 1'b1) begin n_fail++; $display("FAIL clean_rd_en: got %b want 1", arr_rd_en_o); end
        @(negedge clk_i);
        n_checks++; if (arr_clr_dirty_o !== 1'b0) begin n_fail++; $display("FAIL clean_clr: got %b want 0", arr_clr_dirty_o); end
        n_checks++; if (evict_ready_o !== 1'b0) begin n_fail++; $display("FAIL clean_ready_capture: got %b want 0", evict_ready_o); end
        @(negedge clk_i);
        n_checks++; if (evict_ready_o !== 1'b1) begin n_fail++; $display("FAIL clean_ready_back: got %b want 1", evict_ready_o); end
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL clean_mem_valid: got %b want 0", mem_valid_o); end
        @(negedge clk_i);
        n_checks++; if (wb_count_o !== 16'd0) begin n_fail++; $display("FAIL clean_wb_count: got %0d want 0", wb_count_o); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_data;
        logic [29:0] exp_addr;
        do_reset();
        mem_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_line(20'hA0000 + 20'(k), 64'h0123_4567_0000_0000 + 64'(k * 17), 1'b1);
            offer(10'h100 + 10'(k));
            repeat (2) @(negedge clk_i);
        end
        arr_dirty_i = 1'b0;
        n_checks++; if (evict_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", evict_ready_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL bp_overflow_pre: got %b want 0", overflow_o); end
        set_line(20'hA0004, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        offer(10'h104);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow_o); end
        n_checks++; if (arr_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL bp_dropped_rd_en: got %b want 0", arr_rd_en_o); end
        arr_dirty_i = 1'b0;
        n_checks++; if (mem_data_o !== 64'h0123_4567_0000_0000) begin n_fail++; $display("FAIL bp_head_stall: got %h want 0123456700000000", mem_data_o); end
        @(negedge clk_i);
        n_checks++; if (mem_data_o !== 64'h0123_4567_0000_0000) begin n_fail++; $display("FAIL bp_head_stable: got %h want 0123456700000000", mem_data_o); end
        mem_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_data = 64'h0123_4567_0000_0000 + 64'(k * 17);
            exp_addr = {20'hA0000 + 20'(k), 10'h100 + 10'(k)};
            n_checks++; if (mem_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b want 1", k, mem_valid_o); end
            n_checks++; if (mem_addr_o !== exp_addr) begin n_fail++; $display("FAIL bp_addr_%0d: got %h want %h", k, mem_addr_o, exp_addr); end
            n_checks++; if (mem_data_o !== exp_data) begin n_fail++; $display("FAIL bp_data_%0d: got %h want %h", k, mem_data_o, exp_data); end
            @(negedge clk_i);
        end
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", mem_valid_o); end
        n_checks++; if (wb_count_o !== 16'd4) begin n_fail++; $display("FAIL bp_wb_count: got %0d want 4", wb_count_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_back_to_back();
        int acc;
        do_reset();
        mem_ready_i = 1'b1;
        set_line(20'h0, 64'h0, 1'b0);
        acc = 0;
        evict_valid_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            evict_idx_i = 10'(c);
            if (evict_ready_o === 1'b1) acc++;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        evict_valid_i = 1'b0;
        n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 3", acc); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow: got %b want 1", overflow_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_line(20'hB0000 + 20'(k), 64'h5555_0000_0000_0000 + 64'(k), 1'b1);
            offer(10'h020 + 10'(k));
            repeat (2) @(negedge clk_i);
        end
        n_checks++; if (mem_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_queued: got %b want 1", mem_valid_o); end
        set_line(20'hB0002, 64'h5555_0000_0000_0002, 1'b1);
        offer(10'h022);
        @(negedge clk_i);
        n_checks++; if (arr_clr_dirty_o !== 1'b1) begin n_fail++; $display("FAIL rmid_in_capture: got %b want 1", arr_clr_dirty_o); end
        #1 rst_i = 1'b1;
        #1;
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_valid: got %b want 0", mem_valid_o); end
        n_checks++; if (arr_clr_dirty_o !== 1'b0) begin n_fail++; $display("FAIL rmid_clr: got %b want 0", arr_clr_dirty_o); end
        n_checks++; if (wb_count_o !== 16'd0) begin n_fail++; $display("FAIL rmid_wb_count: got %0d want 0", wb_count_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        arr_dirty_i = 1'b0;
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_no_push: got %b want 0", mem_valid_o); end
        n_checks++; if (evict_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", evict_ready_o); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_data;
        do_reset();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_line(20'hC0000 + 20'(i), 64'hC0DE_0000_0000_0000 + 64'(i * 3), 1'b1);
            offer(10'h200 + 10'(i));
            if (i > 0) begin
                exp_data = 64'hC0DE_0000_0000_0000 + 64'((i - 1) * 3);
                n_checks++; if (mem_data_o !== exp_data) begin n_fail++; $display("FAIL wrap_head_%0d: got %h want %h", i, mem_data_o, exp_data); end
                n_checks++; if (evict_ready_o !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_%0d: got %b want 0", i, evict_ready_o); end
            end
            @(negedge clk_i);
            mem_ready_i = (i > 0);
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            exp_data = 64'hC0DE_0000_0000_0000 + 64'(i * 3);
            n_checks++; if (mem_data_o !== exp_data) begin n_fail++; $display("FAIL wrap_data_%0d: got %h want %h", i, mem_data_o, exp_data); end
            n_checks++; if (wb_count_o !== 16'(i)) begin n_fail++; $display("FAIL wrap_count_%0d: got %0d want %0d", i, wb_count_o, i); end
        end
        arr_dirty_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        n_checks++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", mem_valid_o); end
        n_checks++; if (wb_count_o !== 16'd10) begin n_fail++; $display("FAIL wrap_wb_count: got %0d want 10", wb_count_o); end
    endtask

    initial begin
        test_reset();
        test_dirty();
        test_clean();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
